// File: rtl/int8_seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// int8_seq_divider_pkg
//   Shared types and constants for the iterative int8 divider.
//   - div_state_e : controller states (IDLE, CALC, DONE)
//   - INT8_W      : default operand/result width
//   - DIV_ZERO_Q  : quotient reported for a zero divisor (all ones)
// ---------------------------------------------------------------------------
package int8_seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int INT8_W = 8;

  localparam logic [INT8_W-1:0] DIV_ZERO_Q = 8'hFF;

endpackage : int8_seq_divider_pkg

// File: rtl/int8_seq_divider_div_step.sv
// ---------------------------------------------------------------------------
// int8_seq_divider_div_step
//   One combinational restoring-division step: shift the next dividend bit
//   into the partial remainder, trial-subtract the divisor magnitude with a
//   ripple-carry chain of full adders (divisor inverted, carry-in = 1), and
//   keep the difference only when no borrow occurred.
// Ports
//   rem_in   in  WIDTH  partial remainder (always < divisor)
//   bit_in   in  1      next dividend bit, MSB first
//   divisor  in  WIDTH  divisor magnitude (non-zero)
//   rem_out  out WIDTH  updated partial remainder
//   q_bit    out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module int8_seq_divider_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] sub_inv_s;
  logic [WIDTH:0] diff_s;
  logic           carry_s;

  // Ripple-carry subtract shifted - divisor; final carry-out high means no borrow.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    sub_inv_s = ~{1'b0, divisor};
    diff_s    = '0;
    carry_s   = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      diff_s[i] = shifted_s[i] ^ sub_inv_s[i] ^ carry_s;
      carry_s   = (shifted_s[i] & sub_inv_s[i]) |
                  (shifted_s[i] & carry_s) |
                  (sub_inv_s[i] & carry_s);
    end
  end

  // Restore on borrow; either result is below the divisor so it fits WIDTH bits.
  always_comb begin
    q_bit   = carry_s;
    rem_out = carry_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
  end

endmodule : int8_seq_divider_div_step

// File: rtl/int8_seq_divider.sv
// ---------------------------------------------------------------------------
// int8_seq_divider
//   Iterative restoring divider, one quotient bit per clock, valid/ready on
//   both sides, one division in flight. Signed mode divides magnitudes and
//   fixes the signs afterwards (quotient truncated toward zero, remainder
//   takes the dividend's sign).
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     operands valid          in_ready    accepting (IDLE only)
//   dividend     numerator (WIDTH)       divisor     denominator (WIDTH)
//   out_valid    result valid            out_ready   consumer accepts result
//   quotient     result (WIDTH)          remainder   remainder (WIDTH)
//   div_by_zero  divisor was zero for this result
// ---------------------------------------------------------------------------
module int8_seq_divider
  import int8_seq_divider_pkg::*;
#(
  parameter int WIDTH  = INT8_W,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + ONE;
  endfunction

  // |v| in signed mode; the most negative value maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (SIGNED && v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  div_state_e       state_r;
  div_state_e       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dz_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_by_zero_r;
  logic [WIDTH-1:0] rem_step_s;
  logic             q_bit_s;
  logic             accept_s;
  logic             out_fire_s;
  logic             dvs_zero_s;

  int8_seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[WIDTH-1]),
    .divisor (dvs_r),
    .rem_out (rem_step_s),
    .q_bit   (q_bit_s)
  );

  // Handshake qualifiers.
  always_comb begin
    accept_s   = (state_r == IDLE) && in_valid && in_ready_r;
    out_fire_s = out_valid_r && out_ready;
    dvs_zero_s = (divisor == '0);
  end

  // Next-state logic; DONE can only exit once its result is presented.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = dvs_zero_s ? DONE : CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_STEP) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE: begin
        if (out_fire_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register; in_ready is registered from the next state so it only
  // rises on the first clock after reset release or after leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s == IDLE);
    end
  end

  // Datapath: operand capture, per-bit steps, sign fix-up and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r         <= '0;
      dvd_r         <= '0;
      dvs_r         <= '0;
      rem_r         <= '0;
      q_r           <= '0;
      q_neg_r       <= 1'b0;
      r_neg_r       <= 1'b0;
      dz_r          <= 1'b0;
      out_valid_r   <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // A zero divisor skips CALC: preload the final q/r and no sign fix.
            cnt_r   <= '0;
            dvd_r   <= magnitude(dividend);
            dvs_r   <= magnitude(divisor);
            rem_r   <= dvs_zero_s ? dividend : '0;
            q_r     <= dvs_zero_s ? {WIDTH{1'b1}} : '0;
            q_neg_r <= SIGNED && !dvs_zero_s && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= SIGNED && !dvs_zero_s && dividend[WIDTH-1];
            dz_r    <= dvs_zero_s;
          end
        end
        CALC: begin
          rem_r <= rem_step_s;
          q_r   <= {q_r[WIDTH-2:0], q_bit_s};
          dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        DONE: begin
          if (!out_valid_r) begin
            quotient_r    <= q_neg_r ? negate(q_r) : q_r;
            remainder_r   <= r_neg_r ? negate(rem_r) : rem_r;
            div_by_zero_r <= dz_r;
            out_valid_r   <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule : int8_seq_divider

// File: tb/tb_int8_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_int8_seq_divider
//   Drives a signed and an unsigned instance in lockstep with the same
//   operands and handshakes; checks each against its own expected values.
// ---------------------------------------------------------------------------
module tb_int8_seq_divider;
  import int8_seq_divider_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;

  logic       s_in_ready, s_out_valid, s_dz;
  logic [7:0] s_q, s_r;
  logic       u_in_ready, u_out_valid, u_dz;
  logic [7:0] u_q, u_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int8_seq_divider #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(s_out_valid),
    .out_ready(out_ready), .quotient(s_q), .remainder(s_r), .div_by_zero(s_dz)
  );

  int8_seq_divider #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(u_out_valid),
    .out_ready(out_ready), .quotient(u_q), .remainder(u_r), .div_by_zero(u_dz)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] sr;
    logic [7:0] uq;
    logic [7:0] ur;
    logic       dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: language-level division plus the two special cases.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] sq, output logic [7:0] sr,
                       output logic [7:0] uq, output logic [7:0] ur,
                       output logic dz);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 8'h00) begin
      sq = DIV_ZERO_Q; sr = a; uq = DIV_ZERO_Q; ur = a; dz = 1'b1;
    end else begin
      dz = 1'b0;
      uq = a / b;
      ur = a % b;
      sq = 8'(sa / sb);
      sr = 8'(sa % sb);
    end
  endtask

  // Wait for out_valid (bounded); returns the number of edges since accept.
  task automatic wait_result(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!s_out_valid && cycles < 20);
  endtask

  task automatic check_result(input string tag, input logic [7:0] sq, input logic [7:0] sr,
                              input logic [7:0] uq, input logic [7:0] ur, input logic dz);
    check({tag, " s_valid"}, 32'(s_out_valid), 32'd1);
    check({tag, " u_valid"}, 32'(u_out_valid), 32'd1);
    check({tag, " s_q"}, 32'(s_q), 32'(sq));
    check({tag, " s_r"}, 32'(s_r), 32'(sr));
    check({tag, " s_dz"}, 32'(s_dz), 32'(dz));
    check({tag, " u_q"}, 32'(u_q), 32'(uq));
    check({tag, " u_r"}, 32'(u_r), 32'(ur));
    check({tag, " u_dz"}, 32'(u_dz), 32'(dz));
  endtask

  task automatic handshake_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(s_out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] sq, input logic [7:0] sr,
                        input logic [7:0] uq, input logic [7:0] ur, input logic dz);
    int cycles;
    @(negedge clk);
    check({tag, " in_ready"}, 32'({s_in_ready, u_in_ready}), 32'd3);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(cycles);
    check({tag, " latency"}, 32'(cycles), dz ? 32'd1 : 32'd9);
    check_result(tag, sq, sr, uq, ur, dz);
    handshake_out(tag);
  endtask

  initial begin
    int         cycles;
    logic [7:0] a, b, sq, sr, uq, ur;
    logic       dz;

    vecs[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 8'h0E, 8'h02, 1'b0};  // 100 / 7
    vecs[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 8'h16, 8'h02, 1'b0};  // -100 / 7
    vecs[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 8'h00, 8'h64, 1'b0};  // 100 / -7
    vecs[3]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h05, 1'b1};  // 5 / 0
    vecs[4]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0};  // -128 / -1
    vecs[5]  = '{8'h80, 8'h01, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0};  // -128 / 1
    vecs[6]  = '{8'hFF, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};  // 255 / 1
    vecs[7]  = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 8'h7C, 8'h01, 1'b0};  // -7 / 2
    vecs[8]  = '{8'h7F, 8'h7F, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0};
    vecs[9]  = '{8'h03, 8'h80, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0};  // 3 / -128
    vecs[10] = '{8'hF6, 8'h00, 8'hFF, 8'hF6, 8'hFF, 8'hF6, 1'b1};  // -10 / 0
    vecs[11] = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{8'h80, 8'h80, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0};
    vecs[13] = '{8'h81, 8'h0A, 8'hF4, 8'hF9, 8'h0C, 8'h09, 1'b0};  // -127 / 10

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'h00;
    divisor   = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", 32'(s_in_ready), 32'd0);
    check("rst out_valid", 32'({s_out_valid, u_out_valid}), 32'd0);
    check("rst q", 32'(s_q), 32'd0);
    check("rst r", 32'(s_r), 32'd0);
    check("rst dz", 32'(s_dz), 32'd0);
    rst = 1'b0;
    #1;
    check("release in_ready low", 32'(s_in_ready), 32'd0);
    @(posedge clk); #1;
    check("release in_ready high", 32'({s_in_ready, u_in_ready}), 32'd3);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sq, vecs[i].sr,
             vecs[i].uq, vecs[i].ur, vecs[i].dz);
    end

    // Backpressure in DONE with a pending operand held on the input
    @(negedge clk);
    dividend = 8'h32; divisor = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(cycles);
    check("bp latency", 32'(cycles), 32'd9);
    @(negedge clk);
    dividend = 8'h64; divisor = 8'h07; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d valid", k), 32'(s_out_valid), 32'd1);
      check($sformatf("bp hold%0d q", k), 32'({s_q, u_q}), 32'h0A0A);
      check($sformatf("bp hold%0d r", k), 32'({s_r, u_r}), 32'h0000);
      check($sformatf("bp hold%0d in_ready", k), 32'(s_in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release valid", 32'(s_out_valid), 32'd0);
    check("bp release in_ready", 32'(s_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp pending accepted", 32'(s_in_ready), 32'd0);
    wait_result(cycles);
    check("bp pending latency", 32'(cycles), 32'd9);
    check_result("bp pending", 8'h0E, 8'h02, 8'h0E, 8'h02, 1'b0);
    handshake_out("bp pending");

    // Asynchronous reset during CALC
    @(negedge clk);
    dividend = 8'h9C; divisor = 8'h07; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(s_out_valid), 32'd0);
    check("midrst q", 32'({s_q, u_q}), 32'd0);
    check("midrst r", 32'({s_r, u_r}), 32'd0);
    check("midrst in_ready", 32'(s_in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst in_ready back", 32'(s_in_ready), 32'd1);
    run_op("after_rst", 8'h9C, 8'h07, 8'hF2, 8'hFE, 8'h16, 8'h02, 1'b0);

    // Random vectors against the reference model
    for (int n = 0; n < 1500; n++) begin
      a = 8'($urandom_range(0, 255));
      case (n % 8)
        0:       b = 8'h00;
        1:       b = 8'hFF;
        2:       a = 8'h80;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (n % 8 == 2) begin
        b = 8'($urandom_range(0, 255));
      end
      model(a, b, sq, sr, uq, ur, dz);
      run_op($sformatf("rnd%0d", n), a, b, sq, sr, uq, ur, dz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_int8_seq_divider
